// File: rtl/wb_bram_ctrl_if.sv
// Wishbone classic slave bundle between the management SoC and the user BRAM controller.
interface wb_bram_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_bram_ctrl.sv
// Wishbone-to-BRAM controller: window decode, programmable wait states, registered
// BRAM port, single-cycle acknowledge and a saturating completed-access counter.
module wb_bram_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFC0_0000,
    parameter int unsigned DELAYS    = 10,
    parameter int unsigned AW        = 10
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_bram_ctrl_if.slave wbs,
    output logic          bram_en_o,
    output logic [3:0]    bram_we_o,
    output logic [AW-1:0] bram_a_o,
    output logic [31:0]   bram_di_o,
    input  logic [31:0]   bram_do_i,
    output logic          busy_o,
    output logic [15:0]   access_cnt_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_ACK    = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Only the low 16 bits take part in the compare, so huge DELAYS still terminate.
    localparam logic [15:0] DLY = 16'(DELAYS);

    state_t         r_state;
    logic [15:0]    r_cnt;
    logic [AW-1:0]  r_adr;
    logic [31:0]    r_dat;
    logic [3:0]     r_sel;
    logic           r_we;
    logic           r_bram_en;
    logic [3:0]     r_bram_we;
    logic           r_ack;
    logic           r_rd_ack;
    logic           r_busy;
    logic [15:0]    r_access_cnt;

    logic           w_valid;
    logic           w_in_range;
    logic [31:0]    w_dat_o;

    assign w_valid    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_in_range = ((wbs.wbs_adr_i & ADDR_MASK) == ADDR_BASE);

    // BRAM read data only becomes valid during ACK, so it is forwarded, not re-registered.
    always_comb begin
        if (r_rd_ack) begin
            w_dat_o = bram_do_i;
        end else begin
            w_dat_o = 32'h0;
        end
    end

    // Transfer sequencer with registered bus, BRAM and status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'h0;
            r_adr        <= {AW{1'b0}};
            r_dat        <= 32'h0;
            r_sel        <= 4'h0;
            r_we         <= 1'b0;
            r_bram_en    <= 1'b0;
            r_bram_we    <= 4'h0;
            r_ack        <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_busy       <= 1'b0;
            r_access_cnt <= 16'h0;
        end else begin
            r_bram_en    <= 1'b0;
            r_bram_we    <= 4'h0;
            r_ack        <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_access_cnt <= r_access_cnt;
            case (r_state)
                S_IDLE: begin
                    if (w_valid && w_in_range) begin
                        r_adr   <= wbs.wbs_adr_i[AW+1:2];
                        r_dat   <= wbs.wbs_dat_i;
                        r_sel   <= wbs.wbs_sel_i;
                        r_we    <= wbs.wbs_we_i;
                        r_cnt   <= 16'h0;
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end else if (w_valid) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ERR;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!w_valid) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == DLY) begin
                        r_state   <= S_ACCESS;
                        r_bram_en <= 1'b1;
                        r_bram_we <= r_we ? r_sel : 4'h0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_ACCESS: begin
                    r_state  <= S_ACK;
                    r_ack    <= 1'b1;
                    r_rd_ack <= ~r_we;
                end
                S_ACK: begin
                    if (r_access_cnt != 16'hFFFF) begin
                        r_access_cnt <= r_access_cnt + 16'd1;
                    end else begin
                        r_access_cnt <= r_access_cnt;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = w_dat_o;
    assign bram_en_o     = r_bram_en;
    assign bram_we_o     = r_bram_we;
    assign bram_a_o      = r_adr;
    assign bram_di_o     = r_dat;
    assign busy_o        = r_busy;
    assign access_cnt_o  = r_access_cnt;
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: transaction-level timing/memory model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_wb_bram_ctrl;
    localparam int          D    = 10;
    localparam logic [31:0] BASE = 32'h3800_0000;
    localparam logic [31:0] MASK = 32'hFFC0_0000;

    typedef enum int {K_NONE, K_IN, K_OUT} kind_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_a;
    logic [31:0] bram_di;
    logic [31:0] bram_do;
    logic        busy;
    logic [15:0] acnt;

    wb_bram_ctrl_if wb();

    wb_bram_ctrl #(.DELAYS(D)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .wbs          (wb),
        .bram_en_o    (bram_en),
        .bram_we_o    (bram_we),
        .bram_a_o     (bram_a),
        .bram_di_o    (bram_di),
        .bram_do_i    (bram_do),
        .busy_o       (busy),
        .access_cnt_o (acnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // BRAM macro stand-in: registered read, byte-lane writes.
    logic [31:0] bram_mem [0:1023];
    always @(posedge clk) begin
        if (bram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bram_we[i]) bram_mem[bram_a][8*i +: 8] <= bram_di[8*i +: 8];
            end
            bram_do <= bram_mem[bram_a];
        end
    end

    // Reference model state: the active transaction and what the controller must hold.
    logic [31:0] ref_mem [0:1023];
    kind_t       kind = K_NONE;
    int          t0 = 0;
    int          abort_k = 0;
    logic        t_we = 1'b0;
    logic [3:0]  t_sel = 4'h0;
    logic [9:0]  t_word = 10'h0;
    logic [31:0] t_dat = 32'h0;
    logic [9:0]  lat_a = 10'h0;
    logic [31:0] lat_di = 32'h0;
    logic [15:0] model_cnt = 16'h0;
    bit          chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle compare against latencies derived from the transaction start cycle.
    always @(negedge clk) begin
        int k;
        logic e_busy, e_en, e_ack;
        logic [3:0] e_we;
        logic [31:0] e_dat;
        if (chk_on) begin
            k = edge_n - t0;
            e_busy = 1'b0; e_en = 1'b0; e_ack = 1'b0; e_we = 4'h0; e_dat = 32'h0;
            if (kind == K_IN) begin
                if (!(abort_k != 0 && k > abort_k) && k >= 1 && k <= D + 3) begin
                    e_busy = 1'b1;
                    if (k == D + 2) begin
                        e_en = 1'b1;
                        e_we = t_we ? t_sel : 4'h0;
                    end
                    if (k == D + 3) begin
                        e_ack = 1'b1;
                        e_dat = t_we ? 32'h0 : ref_mem[t_word];
                    end
                end
            end else if (kind == K_OUT) begin
                if (k == 1) begin
                    e_busy = 1'b1;
                    e_ack  = 1'b1;
                end
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("bram_en", 32'(bram_en), 32'(e_en));
            chk("bram_we", 32'(bram_we), 32'(e_we));
            chk("ack", 32'(wb.wbs_ack_o), 32'(e_ack));
            chk("dat_o", wb.wbs_dat_o, e_dat);
            chk("bram_a", 32'(bram_a), 32'(lat_a));
            chk("bram_di", bram_di, lat_di);
            chk("access_cnt", 32'(acnt), 32'(model_cnt));
            if (kind == K_IN && abort_k == 0 && k == D + 2 && t_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (t_sel[i]) ref_mem[t_word][8*i +: 8] = t_dat[8*i +: 8];
                end
            end
            if (kind == K_IN && abort_k == 0 && k == D + 3 && model_cnt != 16'hFFFF) begin
                model_cnt = model_cnt + 16'd1;
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ab_k, input int rs_k,
                        output logic [31:0] rdata, output int ack_k, output int en_k,
                        output logic [3:0] en_we, output logic [9:0] en_a);
        int k;
        bit done;
        rdata = 32'h0; ack_k = -1; en_k = -1; en_we = 4'h0; en_a = 10'h0;
        done = 1'b0;
        @(negedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_sel_i = sel;  wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;
        t0 = edge_n; abort_k = ab_k; t_we = we; t_sel = sel; t_word = adr[11:2]; t_dat = dat;
        if ((adr & MASK) == BASE) begin
            kind = K_IN; lat_a = adr[11:2]; lat_di = dat;
        end else begin
            kind = K_OUT;
        end
        while (!done) begin
            @(negedge clk); #1;
            k = edge_n - t0;
            if (bram_en) begin
                en_k = k; en_we = bram_we; en_a = bram_a;
            end
            if (wb.wbs_ack_o) begin
                ack_k = k; rdata = wb.wbs_dat_o; done = 1'b1;
            end else if (rs_k != 0 && k == rs_k) begin
                rst_n = 1'b0;
                wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
                kind = K_NONE; model_cnt = 16'h0; lat_a = 10'h0; lat_di = 32'h0;
                @(negedge clk); #1;
                chk("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_cnt", 32'(acnt), 32'h0);
                rst_n = 1'b1;
                done = 1'b1;
            end else if (k >= D + 8) begin
                done = 1'b1;
            end else if (ab_k != 0 && k == ab_k) begin
                wb.wbs_stb_i = 1'b0;
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int ak, ek;
        logic [3:0] ew;
        logic [9:0] ea;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst_n = 1'b0;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ack", 32'(wb.wbs_ack_o), 32'h0);
        chk("reset_dat", wb.wbs_dat_o, 32'h0);
        chk("reset_en", 32'(bram_en), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_cnt", 32'(acnt), 32'h0);
        t0 = edge_n;
        chk_on = 1'b1;
        rst_n = 1'b1;

        // Write then read back with the default wait-state count.
        xfer(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        chk("wr_en_cycle", ek, 32'd12);
        chk("wr_en_we", 32'(ew), 32'hF);
        chk("wr_en_addr", 32'(ea), 32'd4);
        chk("wr_ack_cycle", ak, 32'd13);
        xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_ack_cycle", ak, 32'd13);
        @(negedge clk); #1;
        chk("cnt_after_two", 32'(acnt), 32'd2);

        // Byte lanes over an all-ones word.
        xfer(1'b1, 32'h3800_0020, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        xfer(1'b1, 32'h3800_0020, 32'h1122_3344, 4'b0101, 0, 0, rd, ak, ek, ew, ea);
        chk("lane_we", 32'(ew), 32'h5);
        xfer(1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        chk("lane_readback", rd, 32'hFF22_FF44);

        // Out-of-range read answers immediately with zero and touches nothing.
        xfer(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        chk("oor_ack_cycle", ak, 32'd1);
        chk("oor_data", rd, 32'h0);
        chk("oor_no_en", ek, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk("oor_cnt", 32'(acnt), 32'd5);

        // Abort during the wait phase leaves memory untouched.
        xfer(1'b1, 32'h3800_0010, 32'hCAFE_F00D, 4'hF, 5, 0, rd, ak, ek, ew, ea);
        chk("abort_no_ack", ak, 32'hFFFF_FFFF);
        chk("abort_no_en", ek, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        chk("abort_readback", rd, 32'hDEAD_BEEF);

        // Reset in the ACCESS cycle: the write has already reached the BRAM.
        xfer(1'b1, 32'h3800_0040, 32'hA5A5_5A5A, 4'hF, 0, D + 2, rd, ak, ek, ew, ea);
        xfer(1'b0, 32'h3800_0040, 32'h0, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        chk("rst_commit_readback", rd, 32'hA5A5_5A5A);

        // Saturation: preload near the top, then run three more accesses.
        @(negedge clk); #1;
        force dut.r_access_cnt = 16'hFFFE;
        model_cnt = 16'hFFFE;
        @(negedge clk); #1;
        release dut.r_access_cnt;
        for (int n = 0; n < 3; n++) begin
            xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, rd, ak, ek, ew, ea);
        end
        @(negedge clk); #1;
        chk("cnt_saturated", 32'(acnt), 32'h0000_FFFF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_bram_ctrl.md
# wb_bram_ctrl

Wishbone-to-BRAM access controller for the user project area. It sits directly upstream of the user BRAM macro and downstream of the management SoC Wishbone slave port (WB MI A). It decodes the user-area address window, inserts a programmable number of wait states, and drives the BRAM port with registered address, data and byte strobes. It returns read data with a single-cycle acknowledge and counts completed accesses.

## Interface
- ADDR_BASE, 32'h3800_0000: base byte address of the BRAM window.
- ADDR_MASK, 32'hFFC0_0000: an address is in range when (wbs_adr_i & ADDR_MASK) == ADDR_BASE.
- DELAYS, 10: wait-state count, range 0..65535.
- AW, 10: BRAM word-address width. The BRAM word address is wbs_adr_i[AW+1:2].

- wb_clk_i  input  1  single clock for all logic.
- wb_rst_i  input  1  synchronous, active-low reset (0 = reset).
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic control signals.
- wbs_sel_i  input  4  byte lane selects.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- bram_en_o  output  1  BRAM enable.
- bram_we_o  output  4  BRAM byte write enables.
- bram_a_o  output  AW  BRAM word address.
- bram_di_o  output  32  BRAM write data.
- bram_do_i  input  32  BRAM read data. It is registered inside the BRAM and is valid on the cycle after bram_en_o.
- busy_o  output  1  high in every state except IDLE.
- access_cnt_o  output  16  count of completed in-range transfers. It saturates at 16'hFFFF.

## Operation
- valid = wbs_cyc_i & wbs_stb_i.
- States: IDLE, WAIT, ACCESS, ACK, ERR.
- IDLE:
  - On valid and in range: latch wbs_adr_i[AW+1:2], wbs_dat_i, wbs_sel_i and wbs_we_i into holding registers; clear the 16-bit wait counter; go to WAIT.
  - On valid and out of range: go to ERR.
- WAIT:
  - If valid drops: go to IDLE (abort). No BRAM access and no ack.
  - Else if cnt == DELAYS: go to ACCESS.
  - Else: cnt <= cnt + 1.
- ACCESS:
  - bram_en_o = 1.
  - bram_we_o = latched sel if latched we, else 4'b0.
  - bram_a_o and bram_di_o come from the holding registers.
  - Next state is ACK unconditionally. Once ACCESS is entered the write is committed.
- ACK:
  - wbs_ack_o = 1.
  - wbs_dat_o = bram_do_i for reads, 32'h0 for writes.
  - access_cnt_o increments unless it is already 16'hFFFF.
  - Next state is IDLE.
- ERR:
  - wbs_ack_o = 1, wbs_dat_o = 32'h0.
  - No BRAM activity and no count increment.
  - Next state is IDLE.
- Outputs outside the states that drive them:
  - wbs_dat_o is 0 whenever wbs_ack_o is 0.
  - bram_en_o and bram_we_o are 0 outside ACCESS.
  - bram_a_o and bram_di_o always reflect the holding registers.
- IDLE never accepts a request on the same cycle a transfer finishes. The controller handles one outstanding transfer; there is no pipelining.

## Timing
- Reset (wb_rst_i = 0 at a clock edge) forces the following on the next cycle:
  - state IDLE, cnt 0, access_cnt_o 0, holding registers 0;
  - wbs_ack_o 0, wbs_dat_o 0, bram_en_o 0, bram_we_o 0, busy_o 0.
- Reset in any state, including ACCESS or ACK, produces no ack and no BRAM enable on the following cycle.
- In-range latency: valid is sampled in IDLE at cycle 0.
  - WAIT occupies cycles 1..DELAYS+1.
  - ACCESS is cycle DELAYS+2.
  - wbs_ack_o is high for exactly one cycle, at cycle DELAYS+3.
  - With DELAYS = 0 the ack is at cycle 3. With DELAYS = 10 the ack is at cycle 13.
- Out-of-range latency: wbs_ack_o at cycle 1, one cycle high.
- Handshake with the master:
  - wbs_ack_o is never asserted unless valid was high on the sampling edge that started the transfer.
  - Input changes during WAIT, ACCESS or ACK are ignored except for the abort check in WAIT.
- When DELAYS >= 65535 the counter comparison still terminates: cnt is 16 bits, compared with DELAYS[15:0], and never wraps before a match.

## Test plan
- Write then read, DELAYS = 10:
  - Write 32'hDEAD_BEEF to 32'h3800_0010 with sel 4'hF.
  - Required: bram_en_o pulses at cycle 12, with bram_we_o = 4'hF and bram_a_o = 4; ack at cycle 13.
  - Read the same address. Required: wbs_dat_o = 32'hDEAD_BEEF with the ack at cycle 13; access_cnt_o = 2.
- Byte lanes: write 32'h1122_3344 with sel 4'b0101 over 32'hFFFF_FFFF.
  - Required: bram_we_o = 4'b0101; readback = 32'hFF22_FF44.
- Out of range: read 32'h2000_0000.
  - Required: ack at cycle 1 with data 0; bram_en_o never asserted; access_cnt_o unchanged.
- Abort: drop wbs_stb_i at cycle 5 of a write with DELAYS = 10.
  - Required: no bram_en_o and no ack; state IDLE at cycle 6; memory unchanged on readback.
- Reset mid-transfer: assert wb_rst_i = 0 in the ACCESS cycle.
  - Required: next cycle has ack 0, busy_o 0, access_cnt_o 0.
- Saturation: preload the count to 16'hFFFE via 2 accesses under a forced-count bench hook, or use a long run.
  - Required: after 3 further accesses, access_cnt_o stays at 16'hFFFF.
